// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - E-stage request / HI-LO response bundle for the divider
interface div_unit_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 annul;
  logic                 stall_div;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall_div, ready, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall_div, ready, result
  );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider (DIV/DIVU), HI=rem LO=quo
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  state_t               stateNext;
  logic [CW-1:0]        counter;
  logic [WIDTH-1:0]     remR;
  logic [WIDTH-1:0]     quoR;
  logic [WIDTH-1:0]     absB;
  logic                 negQ;
  logic                 negR;
  logic [2*WIDTH-1:0]   resultR;

  logic                 accept;
  logic                 lastStep;
  logic [WIDTH-1:0]     absAIn;
  logic [WIDTH-1:0]     absBIn;
  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic [WIDTH-1:0]     remStep;
  logic [WIDTH-1:0]     quoStep;
  logic [WIDTH-1:0]     remFinal;
  logic [WIDTH-1:0]     quoFinal;

  // Operand magnitudes and one restoring step; the quotient register doubles as the dividend shifter.
  always_comb begin
    absAIn   = (bus.signed_div && bus.a[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.a) : bus.a;
    absBIn   = (bus.signed_div && bus.b[WIDTH-1]) ? ({WIDTH{1'b0}} - bus.b) : bus.b;
    shifted  = {remR, quoR[WIDTH-1]};
    trial    = shifted - {1'b0, absB};
    remStep  = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quoStep  = {quoR[WIDTH-2:0], ~trial[WIDTH]};
    quoFinal = negQ ? ({WIDTH{1'b0}} - quoStep) : quoStep;
    remFinal = negR ? ({WIDTH{1'b0}} - remStep) : remStep;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake outputs; annul overrides everything, including the final BUSY step.
  always_comb begin
    stateNext     = state;
    accept        = 1'b0;
    lastStep      = 1'b0;
    bus.stall_div = bus.start && (state != DONE) && !bus.annul;
    bus.ready     = (state == DONE) && !bus.annul;
    case (state)
      IDLE: begin
        accept = bus.start && !bus.annul;
        if (accept) begin
          stateNext = (bus.b == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        lastStep = (counter == CW'(WIDTH - 1));
        if (lastStep) begin
          stateNext = DONE;
        end
      end
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.annul) begin
      stateNext = IDLE;
    end
  end

  // Datapath: latch magnitudes/signs on accept, iterate in BUSY, publish the result on completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      remR    <= '0;
      quoR    <= '0;
      absB    <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      resultR <= '0;
    end else if (accept) begin
      counter <= '0;
      remR    <= '0;
      quoR    <= absAIn;
      absB    <= absBIn;
      negQ    <= bus.signed_div && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      negR    <= bus.signed_div && bus.a[WIDTH-1];
      if (bus.b == '0) begin
        resultR <= {bus.a, {WIDTH{1'b1}}};
      end
    end else if (state == BUSY && !bus.annul) begin
      counter <= counter + 1'b1;
      remR    <= remStep;
      quoR    <= quoStep;
      if (lastStep) begin
        resultR <= {remFinal, quoFinal};
      end
    end
  end

  assign bus.result = resultR;
endmodule
